// File: rtl/vpu_pkg.sv
// vpu_pkg: shared constants, state encoding and word helpers for the vector store path
package vpu_pkg;
  localparam int LANES  = 8;
  localparam int LANE_W = 16;
  localparam int BUS_W  = 32;
  localparam int ADDR_W = 32;
  localparam int WORDS  = LANES * LANE_W / BUS_W;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;
  typedef logic [1:0] widx_t;
  function automatic logic [WORDS-1:0] live_of(input logic [LANES-1:0] m);
    logic [WORDS-1:0] lv;
    for (int k = 0; k < WORDS; k++) lv[k] = |m[2*k +: 2];
    return lv;
  endfunction
  function automatic logic [BUS_W/8-1:0] be_of(input logic [LANES-1:0] m, input widx_t k);
    logic [1:0] p;
    p = m[{k, 1'b0} +: 2];
    return {{2{p[1]}}, {2{p[0]}}};
  endfunction
  // k*s for k in 0..3 as a shift-add, so skipped words cost no extra cycles
  function automatic logic [ADDR_W-1:0] stride_mul(input widx_t k, input logic [ADDR_W-1:0] s);
    return (k[1] ? s << 1 : '0) + (k[0] ? s : '0);
  endfunction
endpackage

// File: rtl/vpu_word_pick.sv
// vpu_word_pick: lowest live word index >= cur; none=1 when no live word remains
module vpu_word_pick
  import vpu_pkg::*;
(
  input  logic [WORDS-1:0] live,
  input  widx_t            cur,
  output widx_t            nxt,
  output logic             none
);
  always_comb begin
    nxt = '0;
    none = 1'b1;
    for (int k = WORDS - 1; k >= 0; k--)
      if (live[k] && widx_t'(k) >= cur) begin
        nxt = widx_t'(k);
        none = 1'b0;
      end
  end
endmodule

// File: rtl/vpu_vstore_seq.sv
// vpu_vstore_seq: serialises a masked 8x16 vector into 32-bit byte-enabled writes, skipping dead words
// ports: in_* request (valid/ready, data, mask, base, stride), flush abort, mem_* write bus with ack, busy/done status
module vpu_vstore_seq
  import vpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_vd,
  input  logic [LANES-1:0]        in_mask,
  input  logic [ADDR_W-1:0]       in_base,
  input  logic [ADDR_W-1:0]       in_stride,
  input  logic                    flush,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [BUS_W-1:0]        mem_wdata,
  output logic [BUS_W/8-1:0]      mem_be,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    done
);
  state_e                  state_q, state_d;
  widx_t                   idx_q, idx_d;
  logic [LANES-1:0]        mask_q, mask_d;
  logic [LANES*LANE_W-1:0] vd_q, vd_d;
  logic [ADDR_W-1:0]       stride_q, stride_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [BUS_W-1:0]        mem_wdata_q, mem_wdata_d;
  logic [BUS_W/8-1:0]      mem_be_q, mem_be_d;
  logic                    done_q, done_d;
  logic                    accept, ack, none;
  logic [WORDS-1:0]        pick_live;
  widx_t                   pick_cur, nxt;
  assign in_ready  = state_q == IDLE && !flush;
  assign busy      = state_q == ISSUE;
  assign accept    = in_valid && in_ready;
  assign ack       = busy && mem_ack;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign done      = done_q;
  // on ack the current word is retired, so the search continues from it with its bit cleared
  assign pick_live = accept ? live_of(in_mask) : live_of(mask_q) & ~(4'b1 << idx_q);
  assign pick_cur  = accept ? '0 : idx_q;
  vpu_word_pick u_pick (
    .live(pick_live),
    .cur (pick_cur),
    .nxt (nxt),
    .none(none)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      vd_q        <= '0;
      stride_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      vd_q        <= vd_d;
      stride_q    <= stride_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
    end
  always_comb
    state_d = state_q == IDLE ? (accept && !none ? ISSUE : IDLE)
                              : (flush || (mem_ack && none) ? IDLE : ISSUE);
  // address runs as an accumulator: base on accept, else previous address plus the index gap times stride
  always_comb begin
    idx_d       = idx_q;
    mask_d      = accept ? in_mask : mask_q;
    vd_d        = accept ? in_vd : vd_q;
    stride_d    = accept ? in_stride : stride_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    if ((accept || ack) && !flush) begin
      mem_req_d = !none;
      done_d    = none;
      mem_be_d  = none ? '0 : be_of(mask_d, nxt);
      if (!none) begin
        idx_d       = nxt;
        mem_addr_d  = (accept ? in_base : mem_addr_q) + stride_mul(accept ? nxt : nxt - idx_q, stride_d);
        mem_wdata_d = vd_d[{nxt, 5'b0} +: BUS_W];
      end
    end
    if (busy && flush) begin
      mem_req_d = 1'b0;
      mem_be_d  = '0;
    end
  end
endmodule

// File: tb/tb_vpu_vstore_seq.sv
// tb_vpu_vstore_seq: table-driven vectors plus directed stall/flush/reset sequences
module tb_vpu_vstore_seq;
  logic         clk, rst, in_valid, in_ready, flush;
  logic [127:0] in_vd;
  logic [7:0]   in_mask;
  logic [31:0]  in_base, in_stride, mem_addr, mem_wdata;
  logic         mem_req, mem_we, mem_ack, busy, done;
  logic [3:0]   mem_be;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [127:0]     vd;
    logic [7:0]       mask;
    logic [31:0]      base;
    logic [31:0]      stride;
    int               n;
    logic [3:0][31:0] addr;
    logic [3:0][31:0] data;
    logic [3:0][3:0]  be;
  } vec_t;
  vec_t vecs[7];
  localparam logic [127:0] VA = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [127:0] VB = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] VC = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
  vpu_vstore_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vd(in_vd),
    .in_mask(in_mask), .in_base(in_base), .in_stride(in_stride), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic start(input logic [127:0] vd, input logic [7:0] m, input logic [31:0] b, input logic [31:0] s, input logic ack);
    @(negedge clk);
    in_vd = vd; in_mask = m; in_base = b; in_stride = s; mem_ack = ack; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_vd = '1; in_mask = 8'hA5;
  endtask
  task automatic run_vec(input int vi);
    int n;
    logic got;
    n = 0;
    got = 1'b0;
    start(vecs[vi].vd, vecs[vi].mask, vecs[vi].base, vecs[vi].stride, 1'b1);
    for (int c = 0; c < 16 && !got; c++) begin
      if (mem_req) begin
        if (n < 4) begin
          chk($sformatf("v%0d addr%0d", vi, n), mem_addr, vecs[vi].addr[n]);
          chk($sformatf("v%0d data%0d", vi, n), mem_wdata, vecs[vi].data[n]);
          chk($sformatf("v%0d be%0d", vi, n), mem_be, vecs[vi].be[n]);
          chk($sformatf("v%0d we%0d", vi, n), mem_we, 1);
          chk($sformatf("v%0d cyc%0d", vi, n), c, n);
        end
        n++;
      end
      if (vecs[vi].n == 0 && c == 0) chk($sformatf("v%0d ready", vi), in_ready, 1);
      if (done) begin
        got = 1'b1;
        chk($sformatf("v%0d done_cyc", vi), c, vecs[vi].n);
        chk($sformatf("v%0d busy_at_done", vi), busy, 0);
      end else @(negedge clk);
    end
    chk($sformatf("v%0d nwrites", vi), n, vecs[vi].n);
    chk($sformatf("v%0d done_seen", vi), got, 1);
  endtask
  initial begin
    vecs[0] = '{VA, 8'hFF, 32'h1000, 32'h4, 4, {32'h100C, 32'h1008, 32'h1004, 32'h1000},
                {32'h0007_0006, 32'h0005_0004, 32'h0003_0002, 32'h0001_0000}, {4'hF, 4'hF, 4'hF, 4'hF}};
    vecs[1] = '{VA, 8'b0100_0001, 32'h2000, 32'h10, 2, {32'h0, 32'h0, 32'h2030, 32'h2000},
                {32'h0, 32'h0, 32'h0007_0006, 32'h0001_0000}, {4'h0, 4'h0, 4'h3, 4'h3}};
    vecs[2] = '{VA, 8'h00, 32'h3000, 32'h4, 0, '0, '0, '0};
    vecs[3] = '{VB, 8'hFF, 32'hFFFF_FFFC, 32'h4, 4, {32'h8, 32'h4, 32'h0, 32'hFFFF_FFFC},
                {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888}, {4'hF, 4'hF, 4'hF, 4'hF}};
    vecs[4] = '{VB, 8'hFF, 32'h100, 32'hFFFF_FFF0, 4, {32'hD0, 32'hE0, 32'hF0, 32'h100},
                {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888}, {4'hF, 4'hF, 4'hF, 4'hF}};
    vecs[5] = '{VC, 8'hC2, 32'h100, 32'hFFFF_FFF0, 2, {32'h0, 32'h0, 32'hD0, 32'h100},
                {32'h0, 32'h0, 32'hDEAD_BEEF, 32'hCAFE_F00D}, {4'h0, 4'h0, 4'hF, 4'hC}};
    vecs[6] = '{VB, 8'h30, 32'h0, 32'h8, 1, {32'h0, 32'h0, 32'h0, 32'h10},
                {32'h0, 32'h0, 32'h0, 32'h3333_4444}, {4'h0, 4'h0, 4'h0, 4'hF}};
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    in_vd = '0; in_mask = '0; in_base = '0; in_stride = '0;
    #2;
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run_vec(i);
    // ack stall on word 1 for five cycles
    start(VA, 8'hFF, 32'h1000, 32'h4, 1'b1);
    chk("stall w0 addr", mem_addr, 32'h1000);
    @(negedge clk);
    mem_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall addr c%0d", c), mem_addr, 32'h1004);
      chk($sformatf("stall data c%0d", c), mem_wdata, 32'h0003_0002);
      chk($sformatf("stall be c%0d", c), mem_be, 4'hF);
      chk($sformatf("stall req c%0d", c), mem_req, 1);
      chk($sformatf("stall done c%0d", c), done, 0);
      if (c < 4) @(negedge clk);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk("stall w2 addr", mem_addr, 32'h1008);
    @(negedge clk);
    chk("stall w3 addr", mem_addr, 32'h100C);
    chk("stall w3 done", done, 0);
    @(negedge clk);
    chk("stall done", done, 1);
    chk("stall req off", mem_req, 0);
    // flush together with ack on word 2
    start(VA, 8'hFF, 32'h1000, 32'h4, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("flush w2 addr", mem_addr, 32'h1008);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush req", mem_req, 0);
    chk("flush done", done, 0);
    chk("flush ready", in_ready, 1);
    chk("flush busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("flush quiet req c%0d", c), mem_req, 0);
      chk($sformatf("flush quiet done c%0d", c), done, 0);
    end
    // flush in IDLE blocks acceptance
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_mask = 8'hFF;
    #1;
    chk("idle flush ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("idle flush busy", busy, 0);
    chk("idle flush req", mem_req, 0);
    chk("idle flush done", done, 0);
    // reset while holding word 0
    start(VA, 8'hFF, 32'h1000, 32'h4, 1'b0);
    chk("prerst req", mem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst req", mem_req, 0);
    chk("midrst busy", busy, 0);
    chk("midrst addr", mem_addr, 0);
    chk("midrst be", mem_be, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
